// File: rtl/switch_defs.sv
// Shared switch constants: port/queue sizing, destination field, counter widths.
// Imported by the VOQ datapath files.
package switch_defs;

  localparam int DEF_PORT_NUM  = 4;
  localparam int DEF_VOQ_DEPTH = 16;

  localparam int WORD_W = 32;
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 30;
  localparam int DEST_W = DEST_MSB - DEST_LSB + 1;

  localparam int DROP_CNT_W = 16;
  localparam int OCC_W = 5;

endpackage

// File: rtl/voq_fifo.sv
// One virtual output queue: circular buffer with wrapping pointers and
// a separate occupancy counter; full queue still accepts a push on pop.
module voq_fifo
  import switch_defs::*;
#(
  parameter int DEPTH = DEF_VOQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              rd_ok;
  logic              wr_ok;

  assign full  = (occ == CNT_W'(DEPTH));
  assign empty = (occ == '0);
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);
  assign head  = mem[rd_ptr];

  // Storage is not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/ingress_voq.sv
// Ingress VOQ bank: steers words by destination, pops on a one-hot grant,
// registers the dequeued word and counts drops on full queues.
module ingress_voq
  import switch_defs::*;
#(
  parameter int PORT_NUM  = DEF_PORT_NUM,
  parameter int VOQ_DEPTH = DEF_VOQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    voq_in_en,
  input  logic [WORD_W-1:0]       voq_in,
  input  logic [PORT_NUM-1:0]     sched_grant,
  output logic                    voq_out_en,
  output logic [WORD_W-1:0]       voq_out,
  output logic [PORT_NUM-1:0]     voq_full,
  output logic [PORT_NUM-1:0]     voq_empty,
  output logic [PORT_NUM*OCC_W-1:0] voq_occ,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int CNT_W = $clog2(VOQ_DEPTH) + 1;

  logic [DEST_W-1:0]   dest;
  logic [PORT_NUM-1:0] push;
  logic [PORT_NUM-1:0] pop;
  logic [WORD_W-1:0]   head [PORT_NUM];
  logic [CNT_W-1:0]    occ  [PORT_NUM];
  logic [WORD_W-1:0]   pop_word;
  logic                grant_1h;
  logic                pop_any;
  logic                drop;

  assign dest = voq_in[DEST_MSB:DEST_LSB];

  assign grant_1h = (sched_grant != '0) &&
    ((sched_grant & (sched_grant - PORT_NUM'(1))) == '0);

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_voq
    assign push[i] = voq_in_en && (dest == DEST_W'(i));
    assign pop[i]  = grant_1h && sched_grant[i] && !voq_empty[i];
    assign voq_occ[OCC_W*i +: OCC_W] = OCC_W'(occ[i]);

    voq_fifo #(
      .DEPTH (VOQ_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (voq_in),
      .head  (head[i]),
      .full  (voq_full[i]),
      .empty (voq_empty[i]),
      .occ   (occ[i])
    );
  end

  assign pop_any = |pop;
  // A full queue popped in the same cycle takes the write instead.
  assign drop = |(push & voq_full & ~pop);

  always_comb begin
    pop_word = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (pop[i]) pop_word = head[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voq_out_en <= 1'b0;
      voq_out    <= '0;
      drop_count <= '0;
    end else begin
      voq_out_en <= pop_any;
      if (pop_any) voq_out <= pop_word;
      if (drop && (drop_count != '1))
        drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ingress_voq.sv
// Bench for ingress_voq: directed vector table, corner sequences and
// a randomized run against a queue-based reference model.
module tb_ingress_voq;

  localparam int P = 4;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          voq_in_en;
  logic [31:0]   voq_in;
  logic [P-1:0]  sched_grant;
  logic          voq_out_en;
  logic [31:0]   voq_out;
  logic [P-1:0]  voq_full;
  logic [P-1:0]  voq_empty;
  logic [P*5-1:0] voq_occ;
  logic [15:0]   drop_count;

  ingress_voq #(.PORT_NUM(P), .VOQ_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .voq_in_en   (voq_in_en),
    .voq_in      (voq_in),
    .sched_grant (sched_grant),
    .voq_out_en  (voq_out_en),
    .voq_out     (voq_out),
    .voq_full    (voq_full),
    .voq_empty   (voq_empty),
    .voq_occ     (voq_occ),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic [3:0]  g;
    logic        xen;
    logic [31:0] xout;
    logic [4:0]  xocc0;
    logic        xemp0;
  } vec_t;

  vec_t tv [10];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq [P][$];
  logic [31:0] w;
  logic [31:0] rd;
  logic [3:0]  g;
  logic        en;
  logic        popv;
  int          rr, gi, dst, acc, drn, obs, drops, s;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] occ_of(int i);
    return voq_occ[5*i +: 5];
  endfunction

  task automatic step(logic e, logic [31:0] d, logic [3:0] gg);
    voq_in_en   = e;
    voq_in      = d;
    sched_grant = gg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{1'b1, 32'h11, 4'b0000, 1'b0, 32'h0,  5'd1, 1'b0};
    tv[1] = '{1'b1, 32'h22, 4'b0000, 1'b0, 32'h0,  5'd2, 1'b0};
    tv[2] = '{1'b0, 32'h0,  4'b0001, 1'b1, 32'h11, 5'd1, 1'b0};
    tv[3] = '{1'b0, 32'h0,  4'b0001, 1'b1, 32'h22, 5'd0, 1'b1};
    tv[4] = '{1'b0, 32'h0,  4'b0011, 1'b0, 32'h22, 5'd0, 1'b1};
    tv[5] = '{1'b0, 32'h0,  4'b0000, 1'b0, 32'h22, 5'd0, 1'b1};
    tv[6] = '{1'b0, 32'h0,  4'b1000, 1'b0, 32'h22, 5'd0, 1'b1};
    tv[7] = '{1'b1, 32'h33, 4'b0001, 1'b0, 32'h22, 5'd1, 1'b0};
    tv[8] = '{1'b0, 32'h0,  4'b0011, 1'b0, 32'h22, 5'd1, 1'b0};
    tv[9] = '{1'b0, 32'h0,  4'b0001, 1'b1, 32'h33, 5'd0, 1'b1};

    reset       = 1'b0;
    voq_in_en   = 1'b0;
    voq_in      = '0;
    sched_grant = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_en", voq_out_en, 0);
    chk("rst_out", voq_out, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_empty", voq_empty, 4'hF);
    chk("rst_full", voq_full, 0);
    chk("rst_occ", voq_occ, 0);
    #2 reset = 1'b1;
    step(1'b0, 0, 0);

    foreach (tv[i]) begin
      step(tv[i].en, tv[i].d, tv[i].g);
      chk($sformatf("tv%0d_en", i), voq_out_en, tv[i].xen);
      chk($sformatf("tv%0d_out", i), voq_out, tv[i].xout);
      chk($sformatf("tv%0d_occ0", i), occ_of(0), tv[i].xocc0);
      chk($sformatf("tv%0d_emp0", i), voq_empty[0], tv[i].xemp0);
      chk($sformatf("tv%0d_occ123", i), voq_occ[19:5], 0);
    end

    for (int k = 0; k < 17; k++) step(1'b1, 32'h8000_0000 + k, 0);
    chk("fill2_full", voq_full, 4'b0100);
    chk("fill2_occ", occ_of(2), 16);
    chk("fill2_drop", drop_count, 1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 0, 4'b0100);
      chk("drain2_en", voq_out_en, 1);
      chk("drain2_out", voq_out, 32'h8000_0000 + k);
    end
    step(1'b0, 0, 4'b0100);
    chk("drain2_lost", voq_out_en, 0);
    chk("drain2_empty", voq_empty[2], 1);

    for (int k = 0; k < 16; k++) step(1'b1, 32'h4000_0000 + k, 0);
    chk("fill1_full", voq_full[1], 1);
    step(1'b1, 32'h4000_0ABC, 4'b0010);
    chk("wp_en", voq_out_en, 1);
    chk("wp_out", voq_out, 32'h4000_0000);
    chk("wp_occ", occ_of(1), 16);
    chk("wp_drop", drop_count, 1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 0, 4'b0010);
      chk("drain1_en", voq_out_en, 1);
      chk("drain1_out", voq_out,
          (k == 16) ? 32'h4000_0ABC : 32'h4000_0000 + k);
    end
    chk("drain1_empty", voq_empty[1], 1);

    for (int k = 1; k <= 3; k++) step(1'b1, k, 0);
    chk("pre_rst_occ0", occ_of(0), 3);
    voq_in_en   = 1'b0;
    sched_grant = 4'b0001;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_en", voq_out_en, 0);
    chk("mid_rst_occ", voq_occ, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_empty", voq_empty, 4'hF);
    #2 reset = 1'b1;
    step(1'b0, 0, 4'b0001);
    chk("post_rst_en", voq_out_en, 0);
    chk("post_rst_out", voq_out, 0);

    rr = 0; acc = 0; drn = 0; obs = 0; drops = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c < 500) begin
        en = ($urandom_range(0, 9) != 0);
        g  = ($urandom_range(0, 1) != 0) ? 4'(1 << rr) : 4'b0;
      end else begin
        en = ($urandom_range(0, 9) < 3);
        g  = ($urandom_range(0, 7) != 0) ? 4'(1 << rr) : 4'b0;
      end
      gi  = rr;
      rr  = (rr + 1) % P;
      dst = $urandom_range(0, P - 1);
      rd  = $urandom;
      w   = {dst[1:0], rd[29:0]};
      popv = (g != 0) && (mq[gi].size() > 0);
      rd = popv ? mq[gi].pop_front() : 32'h0;
      if (popv) drn++;
      if (en) begin
        if (mq[dst].size() < D) begin
          mq[dst].push_back(w);
          acc++;
        end else drops++;
      end
      step(en, w, g);
      chk("rnd_en", voq_out_en, popv);
      if (popv) chk("rnd_out", voq_out, rd);
      if (voq_out_en) obs++;
      for (int i = 0; i < P; i++)
        chk($sformatf("rnd_occ%0d", i), occ_of(i), mq[i].size());
    end
    s = 0;
    for (int i = 0; i < P; i++) s += occ_of(i);
    chk("rnd_drained", obs, drn);
    chk("rnd_conserve", acc, obs + s);
    chk("rnd_drop", drop_count, drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ingress_voq.md
INGRESS_VOQ -- requirements
Module: ingress_voq

Interface
REQ-001 Parameter PORT_NUM, default 4: number of output ports and virtual output queues (VOQs).
REQ-002 Parameter VOQ_DEPTH, default 16: words per VOQ; SHALL be a power of two.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 voq_in_en  in  1  input word valid for one cycle; fed from packet_gen packet_gen_out_en.
REQ-006 voq_in  in  32  packet word; bits [31:30] give the destination port.
REQ-007 sched_grant  in  PORT_NUM  one-hot pop request from the scheduler.
REQ-008 voq_out_en  out  1  output word valid for one cycle; feeds packet_val egress_in_en.
REQ-009 voq_out  out  32  dequeued word; feeds packet_val egress_in.
REQ-010 voq_full  out  PORT_NUM  per-VOQ full flag.
REQ-011 voq_empty  out  PORT_NUM  per-VOQ empty flag.
REQ-012 voq_occ  out  PORT_NUM*5  per-VOQ occupancy, 0..VOQ_DEPTH; VOQ i is at [5i+4:5i].
REQ-013 drop_count  out  16  total words dropped.

Function
REQ-014 On voq_in_en, the block SHALL steer the word to VOQ d = voq_in[31:30].
REQ-015 If VOQ d is not full, the word SHALL be stored at that VOQ's tail. The word is visible in voq_occ the next cycle.
REQ-016 If VOQ d is full and is not popped in the same cycle, the word SHALL be dropped and drop_count SHALL increment by 1, saturating at 0xFFFF.
REQ-017 A pop is valid when sched_grant has exactly one bit set, bit g, and VOQ g is non-empty. On a valid pop:
  - The head word SHALL be removed.
  - Next cycle, voq_out SHALL hold that word and voq_out_en SHALL be 1, for exactly one cycle (latency 1).
REQ-018 A grant with zero bits set, more than one bit set, or pointing at an empty VOQ SHALL perform no pop. voq_out_en SHALL be 0 the next cycle, and voq_out SHALL hold its last value.
REQ-019 Write and pop on the same VOQ in the same cycle:
  - Both SHALL occur and occupancy SHALL be unchanged.
  - When the VOQ is full, the write SHALL be accepted, not dropped.
REQ-020 Write to an empty VOQ with a simultaneous grant to that VOQ: no bypass. The word SHALL be stored, and voq_out_en SHALL be 0 the next cycle.
REQ-021 Write and pop on different VOQs in the same cycle SHALL proceed independently.
REQ-022 Read and write pointers SHALL wrap modulo VOQ_DEPTH. Occupancy SHALL be tracked in a separate counter of log2(VOQ_DEPTH)+1 bits.
REQ-023 voq_full[i] SHALL be 1 when occ_i == VOQ_DEPTH. voq_empty[i] SHALL be 1 when occ_i == 0. Both flags are combinational from the registered occupancy.
REQ-024 Word order within each VOQ SHALL be FIFO. No ordering is guaranteed across VOQs.

Reset
REQ-025 While reset = 0, all state SHALL clear asynchronously:
  - voq_out_en = 0, voq_out = 0, drop_count = 0.
  - All pointers and occupancies = 0, so voq_empty = all 1s and voq_full = 0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words. A pop in flight SHALL NOT produce voq_out_en.
REQ-027 Buffer RAM contents need not be cleared.

Structure
REQ-028 The shared package switch_defs SHALL hold:
  - PORT_NUM and VOQ_DEPTH defaults.
  - DEST_MSB = 31 and DEST_LSB = 30.
  - DROP_CNT_W = 16.
REQ-029 A single-queue sub-module voq_fifo SHALL provide one VOQ:
  - Inputs: push, pop, data in.
  - Outputs: head, full, empty, occ.
REQ-030 ingress_voq SHALL instantiate PORT_NUM copies of voq_fifo and contain the steering, grant decode, output register and drop counter.

Verification
REQ-031 Reset release, then write 0x00000011, 0x00000022 (dest 0), then grant 4'b0001 for two cycles -> voq_out_en on the two following cycles with 0x00000011 then 0x00000022, and voq_empty[0] = 1 afterwards.
REQ-032 Write 17 words with dest 2 (0x80000000..0x80000010), no grants -> voq_full[2] = 1, voq_occ[2] = 16, drop_count = 1, and the 17th word is lost.
REQ-033 VOQ 1 full; in the same cycle write 0x40000ABC and grant 4'b0010 -> the old head is output, occupancy stays 16, drop_count unchanged, and 0x40000ABC is the last word drained.
REQ-034 Grant 4'b0011 or 4'b0000, or a grant to an empty VOQ 3 -> voq_out_en = 0 next cycle and all occupancies unchanged.
REQ-035 Fill VOQ 0 with 3 words, assert reset = 0 for one cycle mid-grant -> voq_out_en = 0, all voq_occ = 0 and drop_count = 0.
REQ-036 Interleave writes to dest 0..3 with round-robin one-hot grants over 1000 random cycles -> per-VOQ FIFO order holds against a scoreboard, and accepted words = drained words + final occupancy.
